// File: rtl/dff_re_tb_pkg.sv
// Shared types and helpers for the D flip-flop response checker.
package dff_re_tb_pkg;

  // Default widths for the timestamp and the saturating counters.
  localparam int DEF_TS_W  = 32;
  localparam int DEF_CNT_W = 16;

  // Run-level checker state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One observation of the DUT: the inputs as applied plus the observed q.
  typedef struct packed {
    logic [DEF_TS_W-1:0] timestamp;
    logic                clk;
    logic                rst_n;
    logic                enable;
    logic                d;
    logic                q;
  } sample_t;

  // Rising edge between two consecutive clock samples.
  function automatic logic rising_edge(input logic prev_clk, input logic cur_clk);
    return (~prev_clk) & cur_clk;
  endfunction

  // Next flip-flop value: reset wins over a clock edge, the edge is gated by enable.
  function automatic logic dff_next(input logic rst_n, input logic clk_edge,
                                    input logic enable, input logic d,
                                    input logic cur_q);
    logic nq;
    if (!rst_n) begin
      nq = 1'b0;
    end else if (clk_edge && enable) begin
      nq = d;
    end else begin
      nq = cur_q;
    end
    return nq;
  endfunction

endpackage

// File: rtl/dff_re_model.sv
// Cycle-accurate reference model of a resettable, enabled D flip-flop.
// Evaluates the presented sample combinationally; state advances only on accept.
module dff_re_model
  import dff_re_tb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                accept,
  input  sample_t             sample,
  output logic                exp_q_next,
  output logic                mismatch,
  output logic [DEF_TS_W-1:0] sample_ts
);

  logic exp_q_r;
  logic prev_clk_r;
  logic first_r;     // no sample seen since the last clear
  logic eff_prev_s;
  logic edge_s;

  // Expected q for the presented sample and its comparison with the observed q.
  always_comb begin
    eff_prev_s = prev_clk_r;
    edge_s     = 1'b0;
    exp_q_next = exp_q_r;
    mismatch   = 1'b0;
    sample_ts  = sample.timestamp;
    // The first sample of a run has no history, so it can never form an edge.
    if (first_r) begin
      eff_prev_s = sample.clk;
    end else begin
      eff_prev_s = prev_clk_r;
    end
    edge_s     = rising_edge(eff_prev_s, sample.clk);
    exp_q_next = dff_next(sample.rst_n, edge_s, sample.enable, sample.d, exp_q_r);
    mismatch   = sample.q ^ exp_q_next;
  end

  // Model state: expected q, previous clock level and the first-sample flag.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      exp_q_r    <= 1'b0;
      prev_clk_r <= 1'b0;
      first_r    <= 1'b1;
    end else if (accept) begin
      exp_q_r    <= exp_q_next;
      prev_clk_r <= sample.clk;
      first_r    <= 1'b0;
    end else begin
      exp_q_r    <= exp_q_r;
      prev_clk_r <= prev_clk_r;
      first_r    <= first_r;
    end
  end

endmodule

// File: rtl/dff_re_checker.sv
// Streaming response checker for a resettable, enabled D flip-flop.
// Holds the run FSM, saturating counters, first-error capture and verdict.
module dff_re_checker
  import dff_re_tb_pkg::*;
#(
  parameter int TS_W  = DEF_TS_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_last,
  input  logic [TS_W-1:0]  s_timestamp,
  input  logic             s_clk,
  input  logic             s_rst_n,
  input  logic             s_enable,
  input  logic             s_d,
  input  logic             s_q,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic             first_err_valid,
  output logic [TS_W-1:0]  first_err_ts,
  output logic             first_err_exp,
  output logic             done,
  output logic             pass
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_e                state_r;
  state_e                state_next_s;
  logic                  accept_s;
  sample_t               sample_s;
  logic                  exp_q_next_s;
  logic                  mismatch_s;
  logic [DEF_TS_W-1:0]   model_ts_s;
  logic [CNT_W-1:0]      sample_count_r;
  logic [CNT_W-1:0]      mismatch_count_r;
  logic [CNT_W-1:0]      samp_next_s;
  logic [CNT_W-1:0]      mism_next_s;
  logic                  first_err_valid_r;
  logic [TS_W-1:0]       first_err_ts_r;
  logic                  first_err_exp_r;
  logic                  done_r;
  logic                  pass_r;

  // Saturating increment: a full counter stays at its maximum.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // A start pulse blocks the handshake so its sample is never half-consumed.
  assign s_ready  = (state_r != DONE) && !start;
  assign accept_s = s_valid && s_ready;

  // Pack the incoming sample; timestamps travel at the package width.
  always_comb begin
    sample_s.timestamp = DEF_TS_W'(s_timestamp);
    sample_s.clk       = s_clk;
    sample_s.rst_n     = s_rst_n;
    sample_s.enable    = s_enable;
    sample_s.d         = s_d;
    sample_s.q         = s_q;
  end

  dff_re_model u_model (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .accept     (accept_s),
    .sample     (sample_s),
    .exp_q_next (exp_q_next_s),
    .mismatch   (mismatch_s),
    .sample_ts  (model_ts_s)
  );

  // Run FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Run FSM next state; start returns to IDLE from anywhere.
  always_comb begin
    state_next_s = state_r;
    if (start) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && s_last) begin
            state_next_s = DONE;
          end else if (accept_s) begin
            state_next_s = RUN;
          end else begin
            state_next_s = IDLE;
          end
        end
        RUN: begin
          if (accept_s && s_last) begin
            state_next_s = DONE;
          end else begin
            state_next_s = RUN;
          end
        end
        DONE:    state_next_s = DONE;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // Next counter values for the sample being accepted this cycle.
  always_comb begin
    samp_next_s = sample_count_r;
    mism_next_s = mismatch_count_r;
    if (accept_s) begin
      samp_next_s = sat_inc(sample_count_r);
      if (mismatch_s) begin
        mism_next_s = sat_inc(mismatch_count_r);
      end else begin
        mism_next_s = mismatch_count_r;
      end
    end else begin
      samp_next_s = sample_count_r;
      mism_next_s = mismatch_count_r;
    end
  end

  // Results: counters, first-error capture and the registered verdict.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      sample_count_r    <= CNT_ZERO;
      mismatch_count_r  <= CNT_ZERO;
      first_err_valid_r <= 1'b0;
      first_err_ts_r    <= {TS_W{1'b0}};
      first_err_exp_r   <= 1'b0;
      done_r            <= 1'b0;
      pass_r            <= 1'b0;
    end else begin
      sample_count_r   <= samp_next_s;
      mismatch_count_r <= mism_next_s;
      if (accept_s && mismatch_s && !first_err_valid_r) begin
        first_err_valid_r <= 1'b1;
        first_err_ts_r    <= TS_W'(model_ts_s);
        first_err_exp_r   <= exp_q_next_s;
      end else begin
        first_err_valid_r <= first_err_valid_r;
        first_err_ts_r    <= first_err_ts_r;
        first_err_exp_r   <= first_err_exp_r;
      end
      // Verdict includes the final sample, so it is built from next-state values.
      done_r <= (state_next_s == DONE);
      pass_r <= (state_next_s == DONE) && (mism_next_s == CNT_ZERO);
    end
  end

  assign sample_count    = sample_count_r;
  assign mismatch_count  = mismatch_count_r;
  assign first_err_valid = first_err_valid_r;
  assign first_err_ts    = first_err_ts_r;
  assign first_err_exp   = first_err_exp_r;
  assign done            = done_r;
  assign pass            = pass_r;

endmodule

// File: tb/tb_dff_re_checker.sv
// Self-checking bench for dff_re_checker: directed table, corner sequences,
// randomized stimulus against a behavioural model, and counter saturation.
module tb_dff_re_checker;
  import dff_re_tb_pkg::*;

  localparam int CMAX = 65535;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, s_last;
  logic [31:0] s_timestamp;
  logic        s_clk, s_rst_n, s_enable, s_d, s_q;
  logic        s_ready, first_err_valid, first_err_exp, done, pass;
  logic [15:0] sample_count, mismatch_count;
  logic [31:0] first_err_ts;

  logic        start4, s_valid4;
  logic        s_ready4, first_err_valid4, first_err_exp4, done4, pass4;
  logic [3:0]  sample_count4, mismatch_count4;
  logic [31:0] first_err_ts4;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural reference state for the main instance.
  bit          r_done, r_first, r_q, r_prev, r_fev, r_fexp;
  int          r_cnt, r_mism;
  int unsigned r_fts;

  dff_re_checker dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .s_timestamp(s_timestamp), .s_clk(s_clk), .s_rst_n(s_rst_n),
    .s_enable(s_enable), .s_d(s_d), .s_q(s_q), .sample_count(sample_count),
    .mismatch_count(mismatch_count), .first_err_valid(first_err_valid),
    .first_err_ts(first_err_ts), .first_err_exp(first_err_exp), .done(done), .pass(pass)
  );

  dff_re_checker #(.TS_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .s_valid(s_valid4), .s_ready(s_ready4),
    .s_last(s_last), .s_timestamp(s_timestamp), .s_clk(s_clk), .s_rst_n(s_rst_n),
    .s_enable(s_enable), .s_d(s_d), .s_q(s_q), .sample_count(sample_count4),
    .mismatch_count(mismatch_count4), .first_err_valid(first_err_valid4),
    .first_err_ts(first_err_ts4), .first_err_exp(first_err_exp4), .done(done4), .pass(pass4)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no $finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic ref_clear();
    r_done = 1'b0; r_first = 1'b1; r_q = 1'b0; r_prev = 1'b0;
    r_cnt = 0; r_mism = 0; r_fev = 1'b0; r_fts = 0; r_fexp = 1'b0;
  endtask

  // Flip-flop value the spec's rules give for the currently driven sample.
  function automatic bit ref_predict(bit c, bit rn, bit en, bit dd);
    bit rising;
    rising = !r_first && !r_prev && c;
    if (!rn) return 1'b0;
    if (rising && en) return dd;
    return r_q;
  endfunction

  task automatic drive(input int unsigned ts, input bit c, input bit rn, input bit en,
                       input bit dd, input bit q, input bit last, input bit v);
    s_timestamp = ts; s_clk = c; s_rst_n = rn; s_enable = en; s_d = dd;
    s_q = q; s_last = last; s_valid = v;
  endtask

  // One clock: check ready, advance the reference at the edge, check all outputs.
  task automatic cycle();
    bit ready_exp, acc, nq;
    #1;
    ready_exp = !r_done && !start;
    chk("s_ready", s_ready, ready_exp);
    acc = s_valid && ready_exp;
    @(posedge clk);
    if (rst || start) begin
      ref_clear();
    end else if (acc) begin
      nq = ref_predict(s_clk, s_rst_n, s_enable, s_d);
      r_q = nq; r_prev = s_clk; r_first = 1'b0;
      if (r_cnt < CMAX) r_cnt++;
      if (s_q != nq) begin
        if (r_mism < CMAX) r_mism++;
        if (!r_fev) begin r_fev = 1'b1; r_fts = s_timestamp; r_fexp = nq; end
      end
      if (s_last) r_done = 1'b1;
    end
    #1;
    chk("sample_count", sample_count, r_cnt);
    chk("mismatch_count", mismatch_count, r_mism);
    chk("first_err_valid", first_err_valid, r_fev);
    chk("first_err_ts", first_err_ts, r_fts);
    chk("first_err_exp", first_err_exp, r_fexp);
    chk("done", done, r_done);
    chk("pass", pass, r_done && (r_mism == 0));
  endtask

  typedef struct {
    bit          pre_start;
    int unsigned ts;
    bit          c, rn, en, dd, q, last;
    int          e_cnt, e_mism;
    bit          e_fev;
    int unsigned e_fts;
    bit          e_fexp, e_done, e_pass;
  } vec_t;

  function automatic vec_t mk(bit ps, int unsigned ts, bit c, bit rn, bit en, bit dd, bit q,
                              bit last, int ec, int em, bit fv, int unsigned ft, bit fe,
                              bit dn, bit ps2);
    vec_t v;
    v.pre_start = ps; v.ts = ts; v.c = c; v.rn = rn; v.en = en; v.dd = dd; v.q = q;
    v.last = last; v.e_cnt = ec; v.e_mism = em; v.e_fev = fv; v.e_fts = ft;
    v.e_fexp = fe; v.e_done = dn; v.e_pass = ps2;
    return v;
  endfunction

  initial begin
    vec_t tbl[15];
    bit pred;
    int unsigned ts;

    // reset sequence, capture/enable, injected faults, reset priority, first-sample
    tbl[0]  = mk(0,   1, 0,0,0,0,0, 0,  1,0, 0, 0,0, 0,0);
    tbl[1]  = mk(0,   2, 1,0,0,0,0, 0,  2,0, 0, 0,0, 0,0);
    tbl[2]  = mk(0,   3, 0,0,0,0,0, 0,  3,0, 0, 0,0, 0,0);
    tbl[3]  = mk(0,   4, 1,0,0,0,0, 1,  4,0, 0, 0,0, 1,1);
    tbl[4]  = mk(1,  10, 0,1,1,1,0, 0,  1,0, 0, 0,0, 0,0);
    tbl[5]  = mk(0,  20, 1,1,1,1,1, 0,  2,0, 0, 0,0, 0,0);
    tbl[6]  = mk(0,  30, 0,1,0,0,1, 0,  3,0, 0, 0,0, 0,0);
    tbl[7]  = mk(0,  40, 1,1,0,0,1, 0,  4,0, 0, 0,0, 0,0);
    tbl[8]  = mk(0,  50, 0,1,1,0,1, 0,  5,0, 0, 0,0, 0,0);
    tbl[9]  = mk(0,  60, 1,1,1,0,1, 0,  6,1, 1,60,0, 0,0);
    tbl[10] = mk(0,  70, 0,1,1,1,0, 0,  7,1, 1,60,0, 0,0);
    tbl[11] = mk(0,  80, 1,1,1,1,0, 0,  8,2, 1,60,0, 0,0);
    tbl[12] = mk(0,  90, 0,1,1,1,1, 0,  9,2, 1,60,0, 0,0);
    tbl[13] = mk(0, 100, 1,0,1,1,0, 1, 10,2, 1,60,0, 1,0);
    tbl[14] = mk(1, 200, 1,1,1,1,0, 1,  1,0, 0, 0,0, 1,1);

    rst = 1'b1; start = 1'b0; start4 = 1'b0; s_valid4 = 1'b0;
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ref_clear();

    // reset state of both instances
    chk("rst_s_ready", s_ready, 1);
    chk("rst_sample_count", sample_count, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_s_ready4", s_ready4, 1);
    chk("rst_mismatch_count4", mismatch_count4, 0);
    cycle();

    // directed table
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].pre_start) begin
        s_valid = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
      end
      drive(tbl[i].ts, tbl[i].c, tbl[i].rn, tbl[i].en, tbl[i].dd, tbl[i].q, tbl[i].last, 1);
      cycle();
      s_valid = 1'b0;
      chk($sformatf("tbl%0d_cnt", i), sample_count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_mism", i), mismatch_count, tbl[i].e_mism);
      chk($sformatf("tbl%0d_fev", i), first_err_valid, tbl[i].e_fev);
      chk($sformatf("tbl%0d_fts", i), first_err_ts, tbl[i].e_fts);
      chk($sformatf("tbl%0d_fexp", i), first_err_exp, tbl[i].e_fexp);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("tbl%0d_pass", i), pass, tbl[i].e_pass);
    end

    // backpressure after the last sample: nothing more is counted
    drive(300, 0, 0, 0, 0, 1, 0, 1);
    repeat (3) cycle();
    chk("bp_s_ready", s_ready, 0);
    chk("bp_sample_count", sample_count, 1);
    chk("bp_mismatch_count", mismatch_count, 0);

    // start together with a valid sample: the sample is dropped
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("start_drop_cnt", sample_count, 0);
    chk("start_drop_mism", mismatch_count, 0);
    chk("start_drop_done", done, 0);
    drive(310, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    chk("after_start_cnt", sample_count, 1);

    // rst mid-run discards everything
    drive(320, 1, 0, 0, 0, 1, 0, 1);
    cycle();
    chk("midrun_mism", mismatch_count, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_cnt", sample_count, 0);
    chk("midrst_fev", first_err_valid, 0);
    chk("midrst_ready", s_ready, 1);

    // randomized stimulus against the behavioural model
    ts = 1000;
    for (int i = 0; i < 700; i++) begin
      ts = ts + 32'd10;
      start = ($urandom % 60 == 0) || (r_done && ($urandom % 4 == 0));
      rst = ($urandom % 250 == 0);
      drive(ts, $urandom % 2, ($urandom % 6) != 0, $urandom % 2, $urandom % 2, 0,
            ($urandom % 12) == 0, ($urandom % 4) != 0);
      pred = ref_predict(s_clk, s_rst_n, s_enable, s_d);
      s_q = pred ^ (($urandom % 10) == 0);
      cycle();
    end
    start = 1'b0; rst = 1'b0; s_valid = 1'b0;
    cycle();

    // saturation on the narrow-counter instance
    for (int i = 0; i < 20; i++) begin
      drive(2000 + i, 0, 0, 0, 0, 1, i == 19, 0);
      s_valid4 = 1'b1;
      cycle();
      if (i == 16) chk("sat_hold_cnt4", sample_count4, 15);
    end
    s_valid4 = 1'b0;
    #1;
    chk("sat_mism4", mismatch_count4, 15);
    chk("sat_cnt4", sample_count4, 15);
    chk("sat_done4", done4, 1);
    chk("sat_pass4", pass4, 0);
    chk("sat_fev4", first_err_valid4, 1);
    chk("sat_fts4", first_err_ts4, 2000);
    chk("sat_fexp4", first_err_exp4, 0);
    chk("sat_ready4", s_ready4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dff_re_checker.md
# dff_re_checker

Streaming response checker that sits directly downstream of the DUT-simulation stage in the split-simulation flow. It consumes one sample per handshake: timestamp, applied clk, rst_n, enable, d, and observed q. It runs a cycle-accurate reference model of the resettable, enabled D flip-flop, compares the model's expected q with the observed q, and reports counts, the first failure, and a final pass/fail verdict.

## Interface
- TS_W, 32, width of sample timestamp
- CNT_W, 16, width of sample and mismatch counters
- clk  in  1  block clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; clears results and re-arms the checker from any state
- s_valid  in  1  sample valid
- s_ready  out  1  checker can accept a sample
- s_last  in  1  marks the final sample of the run
- s_timestamp  in  TS_W  sample timestamp
- s_clk, s_rst_n, s_enable, s_d  in  1 each  DUT inputs as applied for this sample
- s_q  in  1  DUT output observed for this sample
- sample_count  out  CNT_W  accepted samples, saturating
- mismatch_count  out  CNT_W  mismatching samples, saturating
- first_err_valid  out  1  at least one mismatch has been recorded
- first_err_ts  out  TS_W  timestamp of the first mismatch
- first_err_exp  out  1  expected q at the first mismatch
- done  out  1  run complete
- pass  out  1  done and mismatch_count == 0

## Operation
- A sample is accepted when s_valid && s_ready.
- States:
  - IDLE → RUN on the first accepted sample.
  - RUN → DONE on an accepted sample with s_last=1. If that sample is also the first one, IDLE → DONE directly.
  - DONE holds until start or rst.
  - start → IDLE from any state. start has priority over a same-cycle handshake, and that sample is dropped.
- s_ready = 1 in IDLE and RUN, 0 in DONE and in any cycle where start=1.
- Model state: exp_q and prev_clk. Both are cleared to 0 on rst or start.
- Per accepted sample, evaluated in order:
  - If s_rst_n=0, exp_q_next = 0. Reset acts immediately within the sample and has priority over an edge.
  - Else, on a rising edge (prev_clk=0, s_clk=1) with s_enable=1, exp_q_next = s_d.
  - Else, exp_q_next = exp_q.
  - prev_clk ← s_clk in all cases.
  - The first sample after IDLE never produces an edge, because prev_clk is taken as equal to s_clk for that sample.
- Compare s_q with exp_q_next. A mismatch increments mismatch_count.
- On the first mismatch only, latch first_err_ts = s_timestamp and first_err_exp = exp_q_next, and set first_err_valid.
- Both counters saturate at 2^CNT_W−1 and never wrap.
- pass = done && (mismatch_count == 0). A saturated mismatch count still fails.

## Timing
- Reset values: s_ready=1 (state IDLE). sample_count, mismatch_count, first_err_valid, first_err_ts, first_err_exp, done, and pass are all 0.
- One-cycle latency: counters and first_err_* reflect an accepted sample in the cycle after acceptance.
- done and pass rise in the cycle after the s_last sample is accepted. The verdict includes that sample.
- Back-to-back acceptance at one sample per clock while in IDLE/RUN. No throughput bubbles.
- s_ready falls in the same cycle that done rises.
- rst mid-run discards all results with no output of partial state. start behaves identically except that it is a handshake-level input.
- Inputs are held stable by the producer while s_valid=1 && s_ready=0. The checker never samples them then.

## Structure
- Shared package dff_re_tb_pkg:
  - state enum: IDLE, RUN, DONE
  - packed sample struct: timestamp, clk, rst_n, enable, d, q
  - default TS_W/CNT_W constants
- Sub-module dff_re_model holds exp_q/prev_clk and the first-sample flag. It takes the struct plus an accept strobe and returns exp_q_next combinationally.
- The top level holds the FSM, the counters, and the first-error capture.

## Test plan
- Reset sequence: 4 samples with rst_n=0 and q=0, last on the 4th → sample_count=4, mismatch_count=0, done=1 and pass=1 one cycle after the last handshake.
- Capture and enable gating: rst_n=1, enable=1, d=1, clk 0→1 at ts=20, q=1 → no mismatch. Then enable=0, d=0, clk 0→1 at ts=40, q=1 → still no mismatch.
- Injected fault: at ts=60 a rising edge with enable=1, d=0 while the DUT reports q=1 → mismatch_count=1, first_err_valid=1, first_err_ts=60, first_err_exp=0. A second fault at ts=80 → count=2, first_err_ts stays 60.
- Reset priority: rst_n=0 coincident with a rising edge, enable=1, d=1, q=0 → no mismatch.
- Backpressure and restart: drive s_valid continuously through s_last → s_ready=0 afterwards and extra samples are not counted. Pulse start together with s_valid → that sample is dropped, outputs clear, state returns to IDLE.
- Saturation: with CNT_W=4, send 20 mismatching samples → mismatch_count=15 and sample_count=15, pass=0.
